truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper_if.sv | 30 +++
 rtl/truth_table_sweeper.sv | 124 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Handshake and table-load signals between a truth-table sweeper and its host.
interface truth_table_sweeper_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 10
);
   localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int ROWS  = 1 << N_IN;

   logic              lut_we;
   logic [SEL_W-1:0]  lut_sel;
   logic [ROWS-1:0]   lut_data;
   logic              start;
   logic              out_ready;
   logic [N_IN-1:0]   row;
   logic [N_OUT-1:0]  f;
   logic              out_valid;
   logic              busy;
   logic              done;
   logic [N_OUT-1:0]  sig;

   modport master (
      output lut_we, lut_sel, lut_data, start, out_ready,
      input  row, f, out_valid, busy, done, sig
   );

   modport slave (
      input  lut_we, lut_sel, lut_data, start, out_ready,
      output row, f, out_valid, busy, done, sig
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps every input row through N_OUT loadable truth tables, streaming row/f
// over a valid/ready handshake and accumulating a per-function parity signature.
module truth_table_sweeper #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   truth_table_sweeper_if.slave bus
);
   localparam int ROWS = 1 << N_IN;
   localparam logic [N_IN-1:0] ROW_ONE  = N_IN'(1);
   localparam logic [N_IN-1:0] ROW_LAST = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [N_IN-1:0]  row_q;
   logic [N_IN-1:0]  row_next;
   logic [N_OUT-1:0] f_q;
   logic [N_OUT-1:0] f_next;
   logic [N_OUT-1:0] sig_q;
   logic [N_OUT-1:0] sig_next;
   logic [ROWS-1:0]  lut_q    [N_OUT];
   logic [ROWS-1:0]  lut_next [N_OUT];

   logic        xfer;
   logic        lut_wr;
   logic [31:0] sel_ext;

   assign sel_ext = 32'(bus.lut_sel);
   assign lut_wr  = (state == IDLE) && bus.lut_we && (sel_ext < 32'(N_OUT));
   assign xfer    = (state == RUN) && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (xfer && (row_q == ROW_LAST)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      bus.out_valid = (state == RUN);
      bus.busy      = (state != IDLE);
      bus.done      = (state == DONE);
   end

   // f is computed from the post-edge tables and row so it never lags the row it describes.
   always_comb begin
      for (int unsigned j = 0; j < N_OUT; j++) begin
         lut_next[j] = lut_q[j];
         if (lut_wr && (sel_ext == j)) begin
            lut_next[j] = bus.lut_data;
         end
      end

      row_next = row_q;
      sig_next = sig_q;
      if ((state == IDLE) && bus.start) begin
         row_next = '0;
         sig_next = '0;
      end else if (xfer) begin
         row_next = row_q + ROW_ONE;
         sig_next = sig_q ^ f_q;
      end

      f_next = '0;
      for (int unsigned j = 0; j < N_OUT; j++) begin
         f_next[j] = lut_next[j][row_next];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         f_q   <= '0;
         sig_q <= '0;
         for (int unsigned j = 0; j < N_OUT; j++) begin
            lut_q[j] <= '0;
         end
      end else begin
         row_q <= row_next;
         f_q   <= f_next;
         sig_q <= sig_next;
         for (int unsigned j = 0; j < N_OUT; j++) begin
            lut_q[j] <= lut_next[j];
         end
      end
   end

   assign bus.row = row_q;
   assign bus.f   = f_q;
   assign bus.sig = sig_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised and directed bench for truth_table_sweeper against a table-lookup model.
module tb_truth_table_sweeper;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [15:0] mtab [10];

   truth_table_sweeper_if #(.N_IN(4), .N_OUT(10)) bus ();
   truth_table_sweeper_if #(.N_IN(2), .N_OUT(1))  bus2 ();

   truth_table_sweeper #(.N_IN(4), .N_OUT(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   truth_table_sweeper #(.N_IN(2), .N_OUT(1)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] model_f(input int r);
      logic [9:0]  v;
      logic [15:0] t;
      v = '0;
      for (int j = 0; j < 10; j++) begin
         t    = mtab[j];
         v[j] = t[r];
      end
      return v;
   endfunction

   task automatic clear_model();
      for (int j = 0; j < 10; j++) mtab[j] = '0;
   endtask

   task automatic write_lut(input int sel, input logic [15:0] data);
      bus.lut_we   = 1'b1;
      bus.lut_sel  = 4'(sel);
      bus.lut_data = data;
      @(posedge clk); #1;
      bus.lut_we = 1'b0;
      if (sel < 10) mtab[sel] = data;
   endtask

   // Drives one sweep; any lut_we already raised by the caller rides along with start.
   task automatic run_sweep(input string name, input int stall_row, input int stall_len,
                            input int inject_row, input bit rand_ready, output int cycles);
      int         exp_row;
      int         xfers;
      int         stall_left;
      bit         rdy;
      bit         finished;
      logic [9:0] exp_f;
      logic [9:0] exp_sig;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.lut_we = 1'b0;
      exp_row = 0; xfers = 0; exp_sig = '0; stall_left = stall_len;
      cycles = 0; finished = 1'b0; rdy = 1'b1;
      for (int t = 0; t < 200 && !finished; t++) begin
         total++;
         if (xfers == 16) begin
            if ({bus.out_valid, bus.busy, bus.done, bus.row} !== {1'b0, 1'b1, 1'b1, 4'd0}) begin
               bad++;
               $display("FAIL %s_end: valid/busy/done/row got %b%b%b/%0d need 011/0",
                        name, bus.out_valid, bus.busy, bus.done, bus.row);
            end
            finished = 1'b1;
         end else begin
            exp_f = model_f(exp_row);
            if ({bus.out_valid, bus.busy, bus.done, bus.row, bus.f} !==
                {1'b1, 1'b1, 1'b0, 4'(exp_row), exp_f}) begin
               bad++;
               $display("FAIL %s_row: valid/busy/done=%b%b%b row=%0d f=%b need 110 row=%0d f=%b",
                        name, bus.out_valid, bus.busy, bus.done, bus.row, bus.f, exp_row, exp_f);
            end
            if (exp_row == stall_row && stall_left > 0) begin
               rdy = 1'b0;
               stall_left--;
            end else if (rand_ready) begin
               rdy = ($urandom % 4) != 0;
            end else begin
               rdy = 1'b1;
            end
            if (exp_row == inject_row) begin
               bus.start    = 1'b1;
               bus.lut_we   = 1'b1;
               bus.lut_sel  = 4'd3;
               bus.lut_data = 16'hFFFF;
            end
            bus.out_ready = rdy;
            @(posedge clk); #1;
            cycles++;
            bus.start  = 1'b0;
            bus.lut_we = 1'b0;
            if (rdy) begin
               exp_sig = exp_sig ^ exp_f;
               exp_row++;
               xfers++;
            end
         end
      end
      if (!finished) begin
         total++; bad++;
         $display("FAIL %s_timeout: transfers got %0d need 16", name, xfers);
      end
      // out_ready stays high through DONE: must not disturb sig.
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({bus.out_valid, bus.busy, bus.done, bus.sig} !== {1'b0, 1'b0, 1'b0, exp_sig}) begin
         bad++;
         $display("FAIL %s_idle: valid/busy/done=%b%b%b sig=%b need 000 sig=%b",
                  name, bus.out_valid, bus.busy, bus.done, bus.sig, exp_sig);
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({bus.row, bus.f, bus.out_valid, bus.busy, bus.done, bus.sig} !== '0) begin
         bad++;
         $display("FAIL reset_async: row=%0d f=%b v/b/d=%b%b%b sig=%b need all 0",
                  bus.row, bus.f, bus.out_valid, bus.busy, bus.done, bus.sig);
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({bus.row, bus.f, bus.out_valid, bus.busy, bus.done, bus.sig} !== '0) begin
         bad++;
         $display("FAIL reset_release: row=%0d f=%b v/b/d=%b%b%b sig=%b need all 0",
                  bus.row, bus.f, bus.out_valid, bus.busy, bus.done, bus.sig);
      end
      // Mid-cycle reset during an active sweep must clear outputs before the next edge.
      write_lut(3, 16'hEAC0);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({bus.row, bus.f, bus.out_valid, bus.busy, bus.done, bus.sig} !== '0) begin
         bad++;
         $display("FAIL reset_midcycle: row=%0d f=%b v/b/d=%b%b%b sig=%b need all 0",
                  bus.row, bus.f, bus.out_valid, bus.busy, bus.done, bus.sig);
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      clear_model();
   endtask

   task automatic test_ref_sweep();
      int cyc;
      write_lut(3, 16'hEAC0);
      write_lut(4, 16'h8888);
      run_sweep("ref", -1, 0, -1, 1'b0, cyc);
      total++;
      if (cyc !== 16) begin
         bad++;
         $display("FAIL ref_cycles: got %0d need 16", cyc);
      end
      total++;
      if (bus.sig !== 10'b0000001000) begin
         bad++;
         $display("FAIL ref_sig: got %b need 0000001000", bus.sig);
      end
   endtask

   task automatic test_stall();
      int cyc;
      run_sweep("stall", 5, 3, -1, 1'b0, cyc);
      total++;
      if (cyc !== 19) begin
         bad++;
         $display("FAIL stall_cycles: got %0d need 19", cyc);
      end
   endtask

   task automatic test_ignore_busy();
      int cyc;
      run_sweep("ignore", -1, 0, 4, 1'b0, cyc);
      run_sweep("after_ignore", -1, 0, -1, 1'b0, cyc);
      total++;
      if (bus.sig !== 10'b0000001000) begin
         bad++;
         $display("FAIL ignore_sig: got %b need 0000001000", bus.sig);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int cyc;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) begin @(posedge clk); #1; end
      total++;
      if (bus.row !== 4'd8) begin
         bad++;
         $display("FAIL rstmid_row: got %0d need 8", bus.row);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({bus.row, bus.f, bus.out_valid, bus.busy, bus.done, bus.sig} !== '0) begin
         bad++;
         $display("FAIL rstmid_zero: row=%0d f=%b v/b/d=%b%b%b sig=%b need all 0",
                  bus.row, bus.f, bus.out_valid, bus.busy, bus.done, bus.sig);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      bus.out_ready = 1'b0;
      clear_model();
      repeat (2) begin
         @(posedge clk); #1;
         total++;
         if ({bus.done, bus.busy, bus.out_valid} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_nodone: d/b/v got %b%b%b need 000", bus.done, bus.busy, bus.out_valid);
         end
      end
      run_sweep("post_reset", -1, 0, -1, 1'b0, cyc);
      total++;
      if (bus.sig !== 10'd0) begin
         bad++;
         $display("FAIL post_reset_sig: got %b need 0", bus.sig);
      end
   endtask

   task automatic test_random();
      int          cyc;
      int          sel;
      logic [15:0] data;
      for (int it = 0; it < 4; it++) begin
         for (int w = 0; w < 12; w++) begin
            sel  = int'($urandom % 16);
            data = 16'($urandom);
            write_lut(sel, data);
         end
         // Table write coincident with start: first row must already see the new value.
         sel  = int'($urandom % 10);
         data = 16'($urandom);
         bus.lut_we = 1'b1; bus.lut_sel = 4'(sel); bus.lut_data = data;
         mtab[sel] = data;
         run_sweep("random", int'($urandom % 16), int'($urandom % 4), -1, 1'b1, cyc);
      end
   endtask

   task automatic test_small();
      logic [3:0] tab;
      logic       exp_f;
      bit         fin;
      tab = 4'b0110;
      bus2.lut_we = 1'b1; bus2.lut_sel = 1'b1; bus2.lut_data = 4'b1111;
      @(posedge clk); #1;
      bus2.lut_sel = 1'b0; bus2.lut_data = tab;
      @(posedge clk); #1;
      bus2.lut_we = 1'b0;
      bus2.start = 1'b1;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      bus2.out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         exp_f = tab[r];
         total++;
         if ({bus2.out_valid, bus2.row, bus2.f} !== {1'b1, 2'(r), exp_f}) begin
            bad++;
            $display("FAIL small_row: valid=%b row=%0d f=%b need 1 row=%0d f=%b",
                     bus2.out_valid, bus2.row, bus2.f, r, exp_f);
         end
         @(posedge clk); #1;
      end
      fin = 1'b0;
      for (int t = 0; t < 4 && !fin; t++) begin
         if (bus2.done === 1'b1) fin = 1'b1;
         else begin @(posedge clk); #1; end
      end
      total++;
      if (!fin || bus2.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL small_done: done=%b valid=%b need 1 0", bus2.done, bus2.out_valid);
      end
      @(posedge clk); #1;
      total++;
      if ({bus2.busy, bus2.done, bus2.sig} !== 3'b000) begin
         bad++;
         $display("FAIL small_sig: busy/done/sig got %b%b%b need 000", bus2.busy, bus2.done, bus2.sig);
      end
      bus2.out_ready = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      bus.lut_we = 1'b0;  bus.lut_sel = '0;  bus.lut_data = '0;  bus.start = 1'b0;  bus.out_ready = 1'b0;
      bus2.lut_we = 1'b0; bus2.lut_sel = '0; bus2.lut_data = '0; bus2.start = 1'b0; bus2.out_ready = 1'b0;
      clear_model();
      test_reset();
      test_ref_sweep();
      test_stall();
      test_ignore_busy();
      test_reset_mid_sweep();
      test_random();
      test_small();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
